// File: rtl/sram_controller.sv
// MEM-stage responder: one 32-bit access is split into two 16-bit halves on an
// asynchronous SRAM. Each half lasts ACCESS_CYCLES clocks; ready=0 freezes the pipeline.
module sram_controller #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  inout  logic [15:0] sram_dq,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [16:0] word_q;
  logic [31:0] data_q;
  logic        op_wr;
  logic        req;
  logic        last;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign req  = rd_en | wr_en;
  assign last = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word_q    <= '0;
      data_q    <= '0;
      op_wr     <= 1'b0;
      read_data <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req) begin
            // address offset wraps modulo 128K words
            word_q <= 17'((address - BASE_ADDR) >> 2);
            data_q <= write_data;
            op_wr  <= wr_en;
            cnt    <= '0;
          end
        end
        LOW: begin
          cnt <= last ? '0 : cnt + 4'd1;
          if (!op_wr && last) read_data[15:0] <= sram_dq;
        end
        HIGH: begin
          cnt <= last ? '0 : cnt + 4'd1;
          if (!op_wr && last) read_data[31:16] <= sram_dq;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = LOW;
      LOW:     if (last) next_state = HIGH;
      HIGH:    if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sram_addr = '0;
    sram_we_n = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    ready     = 1'b0;
    case (state)
      IDLE: ready = !req;
      LOW: begin
        sram_addr = {word_q, 1'b0};
        sram_we_n = !op_wr;
        dq_oe     = op_wr;
        dq_out    = data_q[15:0];
      end
      HIGH: begin
        sram_addr = {word_q, 1'b1};
        sram_we_n = !op_wr;
        dq_oe     = op_wr;
        dq_out    = data_q[31:16];
      end
      DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign sram_dq = dq_oe ? dq_out : 'z;

endmodule
